bullet_pool: RTL and testbench
==============================

// Module: bullet_pool
// PURPOSE
//  Multi-projectile manager: owns NUM_BULLETS independent bullet slots, launching each from the player on a shoot request.
//  Moves active slots one step per frame, bounces them on per-slot wall collisions, retires them on edge/lifetime/bounce-cap/hit.
//  Sits between keyboard/player logic and the sprite renderer/collision checker; one update per frame_clk.
// PARAMETERS
//  NUM_BULLETS      4    number of slots (1..8)
//  COORD_W          10   coordinate width, unsigned
//  STEP             2    pixels moved per frame per axis
//  X_MAX            639  last valid X; X > X_MAX retires slot
//  Y_MAX            479  last valid Y; Y > Y_MAX retires slot
//  MAX_LIFETIME     120  frames a slot lives (2 s @ 60 fps)
//  BOUNCE_COOLDOWN  10   frames collisions are ignored after a bounce
//  MAX_BOUNCES      3    bounces allowed; next accepted bounce retires slot
//  FIRE_COOLDOWN    15   frames between accepted shots
// PORTS
//  frame_clk     in   1                  sole clock, one tick per video frame
//  Reset         in   1                  synchronous, active-high
//  shoot         in   1                  fire request, level
//  keycode       in   8                  direction key
//  playerX       in   COORD_W            spawn X
//  playerY       in   COORD_W            spawn Y
//  collisionX    in   NUM_BULLETS        per-slot vertical-wall hit
//  collisionY    in   NUM_BULLETS        per-slot horizontal-wall hit
//  kill          in   NUM_BULLETS        per-slot target hit, retire now
//  clear_all     in   1                  retire every slot
//  BulletX       out  NUM_BULLETS*COORD_W  slot i at [i*COORD_W +: COORD_W]
//  BulletY       out  NUM_BULLETS*COORD_W  same packing
//  bullet_active out  NUM_BULLETS        slot live flags
//  fire_ack      out  1                  1-frame pulse on accepted shot
//  fire_slot     out  $clog2(NUM_BULLETS) slot used by last accepted shot
//  active_count  out  $clog2(NUM_BULLETS+1) popcount of bullet_active
// BEHAVIOUR
//  Reset (sync): all outputs 0; all slot counters, velocities, fire cooldown 0.
//  Keycode map: 52/0C up (0,-STEP); 51/0E down (0,+STEP); 50/0D left (-STEP,0); 4F/0F right (+STEP,0); other = invalid.
//  Fire accepted iff shoot & fire_cd==0 & valid key & some slot free (from registered bullet_active at frame start).
//   Chosen slot = lowest free index. Next frame: pos=player, vel=key dir, life=0, bounces=0, bcd=0, active=1.
//   fire_ack=1 that frame, fire_slot updated. fire_cd<=FIRE_COOLDOWN, then decrements to 0.
//   Invalid key or pool full: request dropped, no ack, fire_cd unchanged.
//  Per active slot, priority high->low each frame:
//   1 clear_all or kill[i]: active<=0.
//   2 life>=MAX_LIFETIME-1: active<=0.
//   3 next pos out of range: retire. Signed COORD_W+1 math; next<0 or >MAX retires; no wrap-around.
//   4 bcd==0 & (collisionX[i]|collisionY[i]):
//     If bounces==MAX_BOUNCES, retire.
//     Else negate vel on hit axis (both if both), bounces++, bcd<=BOUNCE_COOLDOWN.
//     Position advances with the new velocity the same frame.
//   5 bcd!=0: collisions ignored, bcd--.
//   Otherwise pos+=vel, life++.
//  Retired slot: pos holds last value, vel/counters hold; becomes free next frame, never refilled same frame.
//  clear_all same frame as accepted shot: clear wins, no ack; fire_cd untouched.
//  Inputs for inactive slots ignored. active_count is registered, consistent with bullet_active.
//  Latency: shoot -> active/ack 1 frame; collision -> reversed motion visible 1 frame.
// STRUCTURE
//  bullet_pkg: dir_e enum (DIR_NONE/UP/DOWN/LEFT/RIGHT), keycode localparams, key_to_dir() function.
//  bullet_pkg also holds a vel_t struct of signed DX/DY.
//  Sub-module bullet_slot (one per slot, generate loop): pos/vel/life/bcd/bounce regs, spawn/kill inputs.
//  Top holds priority-encoder free-slot pick, fire cooldown, popcount.
// TESTING
//  Reset mid-flight with 3 live slots -> next frame all outputs 0, fire_cd 0.
//  shoot + key 4F, player (100,50) -> slot0 active at (100,50), ack 1 frame; next frame (102,50).
//  shoot held 40 frames, key 52 -> accepts at frames 0,15,30, slots 0,1,2; no ack between.
//  Slot moving left with collisionX held: bounces at frames f, f+11, f+22; 4th accepted hit retires slot.
//  Slot at X=1 moving left -> retires, never shows X=1023; life reaches 119 -> retires that frame.
//  Pool full (NUM_BULLETS live) + shoot -> no ack; kill[2] -> next accepted shot lands in slot 2.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared types for the bullet pool: direction enum, keycode map, velocity struct.
// Pure declarations; no timing, no flow control.
package bullet_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    localparam logic [7:0] KEY_UP_A    = 8'h52;
    localparam logic [7:0] KEY_UP_B    = 8'h0C;
    localparam logic [7:0] KEY_DOWN_A  = 8'h51;
    localparam logic [7:0] KEY_DOWN_B  = 8'h0E;
    localparam logic [7:0] KEY_LEFT_A  = 8'h50;
    localparam logic [7:0] KEY_LEFT_B  = 8'h0D;
    localparam logic [7:0] KEY_RIGHT_A = 8'h4F;
    localparam logic [7:0] KEY_RIGHT_B = 8'h0F;

    localparam int VEL_W = 8;

    typedef struct packed {
        logic signed [VEL_W-1:0] dx;
        logic signed [VEL_W-1:0] dy;
    } vel_t;

    function automatic dir_e key_to_dir(input logic [7:0] key);
        case (key)
            KEY_UP_A,    KEY_UP_B:    return DIR_UP;
            KEY_DOWN_A,  KEY_DOWN_B:  return DIR_DOWN;
            KEY_LEFT_A,  KEY_LEFT_B:  return DIR_LEFT;
            KEY_RIGHT_A, KEY_RIGHT_B: return DIR_RIGHT;
            default:                  return DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: spawn, per-frame move, wall bounce with cooldown, retirement.
// State updates one frame after inputs; no backpressure (one update per frame).
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int COORD_W         = 10,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int MAX_LIFETIME    = 120,
    parameter int BOUNCE_COOLDOWN = 10,
    parameter int MAX_BOUNCES     = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_spawn,
    input  logic [COORD_W-1:0] i_spawn_x,
    input  logic [COORD_W-1:0] i_spawn_y,
    input  vel_t               i_spawn_vel,
    input  logic               i_kill,
    input  logic               i_col_x,
    input  logic               i_col_y,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_active,
    output logic               o_active_nxt
);

    localparam int SW    = COORD_W + 2;
    localparam int LW    = $clog2(MAX_LIFETIME + 1);
    localparam int BCD_W = $clog2(BOUNCE_COOLDOWN + 1);
    localparam int BNC_W = $clog2(MAX_BOUNCES + 1);
    localparam logic signed [SW-1:0] XM = SW'(X_MAX);
    localparam logic signed [SW-1:0] YM = SW'(Y_MAX);
    localparam logic [LW-1:0]    LIFE_LAST = LW'(MAX_LIFETIME - 1);
    localparam logic [BCD_W-1:0] BCD_LOAD  = BCD_W'(BOUNCE_COOLDOWN);
    localparam logic [BNC_W-1:0] BNC_CAP   = BNC_W'(MAX_BOUNCES);

    logic [COORD_W-1:0] r_x, r_y, w_x, w_y;
    vel_t               r_vel, w_vel, w_bvel;
    logic [LW-1:0]      r_life, w_life;
    logic [BCD_W-1:0]   r_bcd, w_bcd;
    logic [BNC_W-1:0]   r_bnc, w_bnc;
    logic               r_active, w_active;
    logic signed [SW-1:0] w_nx, w_ny, w_bx, w_by;

    // Extra headroom bit keeps negative and >MAX results distinguishable, so no wrap.
    function automatic logic signed [SW-1:0] step_pos(input logic [COORD_W-1:0] p,
                                                      input logic signed [VEL_W-1:0] d);
        return $signed({2'b00, p}) + SW'(d);
    endfunction

    function automatic logic out_of_range(input logic signed [SW-1:0] n,
                                          input logic signed [SW-1:0] lim);
        return n[SW-1] || (n > lim);
    endfunction

    always_comb begin
        w_bvel    = r_vel;
        if (i_col_x) w_bvel.dx = -r_vel.dx;
        if (i_col_y) w_bvel.dy = -r_vel.dy;
        w_nx      = step_pos(r_x, r_vel.dx);
        w_ny      = step_pos(r_y, r_vel.dy);
        w_bx      = step_pos(r_x, w_bvel.dx);
        w_by      = step_pos(r_y, w_bvel.dy);

        w_x       = r_x;
        w_y       = r_y;
        w_vel     = r_vel;
        w_life    = r_life;
        w_bcd     = r_bcd;
        w_bnc     = r_bnc;
        w_active  = r_active;

        if (i_spawn) begin
            w_x      = i_spawn_x;
            w_y      = i_spawn_y;
            w_vel    = i_spawn_vel;
            w_life   = '0;
            w_bcd    = '0;
            w_bnc    = '0;
            w_active = 1'b1;
        end else if (r_active) begin
            if (i_kill) begin
                w_active = 1'b0;
            end else if (r_life >= LIFE_LAST) begin
                w_active = 1'b0;
            end else if (out_of_range(w_nx, XM) || out_of_range(w_ny, YM)) begin
                w_active = 1'b0;
            end else if (r_bcd == '0 && (i_col_x || i_col_y)) begin
                if (r_bnc == BNC_CAP || out_of_range(w_bx, XM) || out_of_range(w_by, YM)) begin
                    w_active = 1'b0;
                end else begin
                    w_vel  = w_bvel;
                    w_x    = w_bx[COORD_W-1:0];
                    w_y    = w_by[COORD_W-1:0];
                    w_bnc  = r_bnc + 1'b1;
                    w_bcd  = BCD_LOAD;
                    w_life = r_life + 1'b1;
                end
            end else begin
                if (r_bcd != '0) w_bcd = r_bcd - 1'b1;
                w_x    = w_nx[COORD_W-1:0];
                w_y    = w_ny[COORD_W-1:0];
                w_life = r_life + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_vel    <= '0;
            r_life   <= '0;
            r_bcd    <= '0;
            r_bnc    <= '0;
            r_active <= 1'b0;
        end else begin
            r_x      <= w_x;
            r_y      <= w_y;
            r_vel    <= w_vel;
            r_life   <= w_life;
            r_bcd    <= w_bcd;
            r_bnc    <= w_bnc;
            r_active <= w_active;
        end
    end

    assign o_x          = r_x;
    assign o_y          = r_y;
    assign o_active     = r_active;
    assign o_active_nxt = i_rst ? 1'b0 : w_active;

endmodule

// File: rtl/bullet_pool.sv
// Bullet pool: lowest-free slot allocation, fire cooldown, live-slot popcount.
// Shot and motion visible one frame after request; dropped shots are not queued.
module bullet_pool
    import bullet_pkg::*;
#(
    parameter int NUM_BULLETS     = 4,
    parameter int COORD_W         = 10,
    parameter int STEP            = 2,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int MAX_LIFETIME    = 120,
    parameter int BOUNCE_COOLDOWN = 10,
    parameter int MAX_BOUNCES     = 3,
    parameter int FIRE_COOLDOWN   = 15,
    localparam int SLW   = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1,
    localparam int CNT_W = $clog2(NUM_BULLETS + 1)
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic                           shoot,
    input  logic [7:0]                     keycode,
    input  logic [COORD_W-1:0]             playerX,
    input  logic [COORD_W-1:0]             playerY,
    input  logic [NUM_BULLETS-1:0]         collisionX,
    input  logic [NUM_BULLETS-1:0]         collisionY,
    input  logic [NUM_BULLETS-1:0]         kill,
    input  logic                           clear_all,
    output logic [NUM_BULLETS*COORD_W-1:0] BulletX,
    output logic [NUM_BULLETS*COORD_W-1:0] BulletY,
    output logic [NUM_BULLETS-1:0]         bullet_active,
    output logic                           fire_ack,
    output logic [SLW-1:0]                 fire_slot,
    output logic [CNT_W-1:0]               active_count
);

    localparam int FCD_W = $clog2(FIRE_COOLDOWN + 1);
    // Loading one less than the cooldown puts accepted shots exactly FIRE_COOLDOWN frames apart.
    localparam logic [FCD_W-1:0] FCD_LOAD = (FIRE_COOLDOWN > 0) ? FCD_W'(FIRE_COOLDOWN - 1) : '0;

    logic [FCD_W-1:0]       r_fire_cd;
    logic                   r_fire_ack;
    logic [SLW-1:0]         r_fire_slot;
    logic [CNT_W-1:0]       r_count;
    logic [SLW-1:0]         w_pick;
    logic                   w_any_free;
    logic                   w_fire;
    dir_e                   w_dir;
    vel_t                   w_vel;
    logic [NUM_BULLETS-1:0] w_act_nxt;
    logic [CNT_W-1:0]       w_cnt;

    assign w_dir      = key_to_dir(keycode);
    assign w_any_free = ~&bullet_active;
    assign w_fire     = shoot && (r_fire_cd == '0) && (w_dir != DIR_NONE)
                        && w_any_free && !clear_all;

    always_comb begin
        w_pick = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!bullet_active[i]) w_pick = SLW'(i);
        end
    end

    always_comb begin
        w_vel = '0;
        case (w_dir)
            DIR_UP:    w_vel.dy = VEL_W'(-STEP);
            DIR_DOWN:  w_vel.dy = VEL_W'(STEP);
            DIR_LEFT:  w_vel.dx = VEL_W'(-STEP);
            DIR_RIGHT: w_vel.dx = VEL_W'(STEP);
            default:   w_vel    = '0;
        endcase
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        bullet_slot #(
            .COORD_W        (COORD_W),
            .X_MAX          (X_MAX),
            .Y_MAX          (Y_MAX),
            .MAX_LIFETIME   (MAX_LIFETIME),
            .BOUNCE_COOLDOWN(BOUNCE_COOLDOWN),
            .MAX_BOUNCES    (MAX_BOUNCES)
        ) u_slot (
            .i_clk       (frame_clk),
            .i_rst       (Reset),
            .i_spawn     (w_fire && (w_pick == SLW'(g))),
            .i_spawn_x   (playerX),
            .i_spawn_y   (playerY),
            .i_spawn_vel (w_vel),
            .i_kill      (clear_all || kill[g]),
            .i_col_x     (collisionX[g]),
            .i_col_y     (collisionY[g]),
            .o_x         (BulletX[g*COORD_W +: COORD_W]),
            .o_y         (BulletY[g*COORD_W +: COORD_W]),
            .o_active    (bullet_active[g]),
            .o_active_nxt(w_act_nxt[g])
        );
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_cnt = w_cnt + CNT_W'(w_act_nxt[i]);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_fire_cd   <= '0;
            r_fire_ack  <= 1'b0;
            r_fire_slot <= '0;
            r_count     <= '0;
        end else begin
            r_fire_ack <= w_fire;
            r_count    <= w_cnt;
            if (w_fire) begin
                r_fire_cd   <= FCD_LOAD;
                r_fire_slot <= w_pick;
            end else if (r_fire_cd != '0) begin
                r_fire_cd <= r_fire_cd - 1'b1;
            end
        end
    end

    assign fire_ack     = r_fire_ack;
    assign fire_slot    = r_fire_slot;
    assign active_count = r_count;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: vector table for single-slot behaviour, hand sequences for
// cooldown spacing, pool-full, reset, edge retirement, bounce cap and lifetime.
module tb_bullet_pool;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b0;
    logic        shoot = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  playerX = '0;
    logic [9:0]  playerY = '0;
    logic [3:0]  collisionX = '0;
    logic [3:0]  collisionY = '0;
    logic [3:0]  kill = '0;
    logic        clear_all = 1'b0;
    logic [39:0] BulletX;
    logic [39:0] BulletY;
    logic [3:0]  bullet_active;
    logic        fire_ack;
    logic [1:0]  fire_slot;
    logic [2:0]  active_count;

    int total = 0;
    int bad   = 0;

    bullet_pool dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .shoot        (shoot),
        .keycode      (keycode),
        .playerX      (playerX),
        .playerY      (playerY),
        .collisionX   (collisionX),
        .collisionY   (collisionY),
        .kill         (kill),
        .clear_all    (clear_all),
        .BulletX      (BulletX),
        .BulletY      (BulletY),
        .bullet_active(bullet_active),
        .fire_ack     (fire_ack),
        .fire_slot    (fire_slot),
        .active_count (active_count)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int         pre;
        logic       sh;
        logic [7:0] key;
        int         px, py;
        logic [3:0] cx, cy, kl;
        logic       clr;
        logic       e_ack;
        logic [3:0] e_act;
        int         e_x, e_y;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(int pre, logic sh, logic [7:0] key, int px, int py,
                                logic [3:0] cx, logic [3:0] cy, logic [3:0] kl, logic clr,
                                logic e_ack, logic [3:0] e_act, int e_x, int e_y);
        vec_t v;
        v.pre = pre; v.sh = sh; v.key = key; v.px = px; v.py = py;
        v.cx = cx; v.cy = cy; v.kl = kl; v.clr = clr;
        v.e_ack = e_ack; v.e_act = e_act; v.e_x = e_x; v.e_y = e_y;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic idle_inputs();
        shoot = 1'b0; keycode = 8'h00; collisionX = '0; collisionY = '0;
        kill = '0; clear_all = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".active"}, 64'(bullet_active), 64'd0);
        chk({nm, ".x"},      64'(BulletX), 64'd0);
        chk({nm, ".y"},      64'(BulletY), 64'd0);
        chk({nm, ".ack"},    64'(fire_ack), 64'd0);
        chk({nm, ".slot"},   64'(fire_slot), 64'd0);
        chk({nm, ".count"},  64'(active_count), 64'd0);
    endtask

    initial begin
        // pre, sh, key, px, py, cx, cy, kill, clr | ack, active, x0, y0
        vecs[0]  = mk(0,  1, 8'h4F, 100, 50,  4'h0, 4'h0, 4'h0, 0,  1, 4'h1, 100, 50);
        vecs[1]  = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h0, 4'h0, 0,  0, 4'h1, 102, 50);
        vecs[2]  = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h0, 4'h1, 0,  0, 4'h0, 102, 50);
        vecs[3]  = mk(12, 1, 8'h0C, 200, 300, 4'h0, 4'h0, 4'h0, 0,  1, 4'h1, 200, 300);
        vecs[4]  = mk(0,  1, 8'h0E, 5,   5,   4'h0, 4'h0, 4'h0, 0,  0, 4'h1, 200, 298);
        vecs[5]  = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h0, 4'h1, 0,  0, 4'h0, 200, 298);
        vecs[6]  = mk(12, 1, 8'h99, 5,   5,   4'h0, 4'h0, 4'h0, 0,  0, 4'h0, 200, 298);
        vecs[7]  = mk(0,  1, 8'h51, 10,  20,  4'h0, 4'h0, 4'h0, 0,  1, 4'h1, 10,  20);
        vecs[8]  = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h0, 4'h0, 0,  0, 4'h1, 10,  22);
        vecs[9]  = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h0, 4'h0, 1,  0, 4'h0, 10,  22);
        vecs[10] = mk(12, 1, 8'h50, 300, 300, 4'h0, 4'h0, 4'h0, 1,  0, 4'h0, 10,  22);
        vecs[11] = mk(0,  1, 8'h52, 300, 300, 4'h0, 4'h0, 4'h0, 0,  1, 4'h1, 300, 300);
        vecs[12] = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h0, 4'h0, 0,  0, 4'h1, 300, 298);
        vecs[13] = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h1, 4'h0, 0,  0, 4'h1, 300, 300);
        vecs[14] = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h0, 4'h0, 0,  0, 4'h1, 300, 302);
        vecs[15] = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h1, 4'h0, 0,  0, 4'h1, 300, 304);
        vecs[16] = mk(8,  0, 8'h00, 0,   0,   4'h0, 4'h1, 4'h0, 0,  0, 4'h1, 300, 318);
        vecs[17] = mk(0,  0, 8'h00, 0,   0,   4'h0, 4'h0, 4'h1, 0,  0, 4'h0, 300, 318);

        #2;
        do_reset();
        chk_all_zero("reset");

        for (int r = 0; r < 18; r++) begin
            idle_inputs();
            for (int p = 0; p < vecs[r].pre; p++) step();
            shoot = vecs[r].sh; keycode = vecs[r].key;
            playerX = 10'(vecs[r].px); playerY = 10'(vecs[r].py);
            collisionX = vecs[r].cx; collisionY = vecs[r].cy;
            kill = vecs[r].kl; clear_all = vecs[r].clr;
            step();
            chk($sformatf("vec%0d.ack", r),    64'(fire_ack), 64'(vecs[r].e_ack));
            chk($sformatf("vec%0d.active", r), 64'(bullet_active), 64'(vecs[r].e_act));
            chk($sformatf("vec%0d.count", r),  64'(active_count), 64'($countones(vecs[r].e_act)));
            chk($sformatf("vec%0d.x0", r),     64'(BulletX[9:0]), 64'(vecs[r].e_x));
            chk($sformatf("vec%0d.y0", r),     64'(BulletY[9:0]), 64'(vecs[r].e_y));
            chk($sformatf("vec%0d.slot", r),   64'(fire_slot), 64'd0);
        end

        // Held shoot: accepts every 15 frames into successive slots.
        do_reset();
        playerX = 10'd100; playerY = 10'd400; keycode = 8'h52;
        shoot = 1'b1;
        for (int f = 0; f < 40; f++) begin
            step();
            chk($sformatf("hold%0d.ack", f), 64'(fire_ack), 64'((f % 15) == 0));
            if ((f % 15) == 0) chk($sformatf("hold%0d.slot", f), 64'(fire_slot), 64'(f / 15));
        end
        chk("hold.active", 64'(bullet_active), 64'h7);
        chk("hold.count",  64'(active_count), 64'd3);
        shoot = 1'b0;
        for (int f = 40; f < 45; f++) step();
        shoot = 1'b1;
        step();
        chk("fill.ack",  64'(fire_ack), 64'd1);
        chk("fill.slot", 64'(fire_slot), 64'd3);
        chk("fill.count", 64'(active_count), 64'd4);
        shoot = 1'b0;
        for (int f = 46; f < 60; f++) step();
        shoot = 1'b1;
        step();
        chk("full.ack",    64'(fire_ack), 64'd0);
        chk("full.active", 64'(bullet_active), 64'hF);
        shoot = 1'b0; kill = 4'b0100;
        step();
        chk("kill2.active", 64'(bullet_active), 64'hB);
        chk("kill2.count",  64'(active_count), 64'd3);
        kill = '0; shoot = 1'b1;
        step();
        chk("refill.ack",    64'(fire_ack), 64'd1);
        chk("refill.slot",   64'(fire_slot), 64'd2);
        chk("refill.active", 64'(bullet_active), 64'hF);
        chk("refill.y2",     64'(BulletY[29:20]), 64'd400);

        // Reset with slots in flight, then an immediate shot proves cooldown was cleared.
        shoot = 1'b1;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk_all_zero("midreset");
        keycode = 8'h4F; playerX = 10'd1; playerY = 10'd1;
        step();
        chk("postreset.ack", 64'(fire_ack), 64'd1);

        // Left-moving slot at X=1 retires instead of wrapping.
        do_reset();
        shoot = 1'b1; keycode = 8'h50; playerX = 10'd1; playerY = 10'd100;
        step();
        chk("edge.spawn_x", 64'(BulletX[9:0]), 64'd1);
        chk("edge.spawn_act", 64'(bullet_active), 64'h1);
        idle_inputs();
        step();
        chk("edge.active", 64'(bullet_active), 64'h0);
        chk("edge.x_hold", 64'(BulletX[9:0]), 64'd1);
        chk("edge.count",  64'(active_count), 64'd0);

        // Held vertical-wall hit: bounces 11 frames apart, fourth accepted hit retires.
        do_reset();
        shoot = 1'b1; keycode = 8'h50; playerX = 10'd600; playerY = 10'd200;
        step();
        idle_inputs();
        collisionX = 4'b0001;
        for (int k = 1; k <= 34; k++) begin
            step();
            case (k)
                1:  chk("bnc1.x",  64'(BulletX[9:0]), 64'd602);
                11: chk("bnc11.x", 64'(BulletX[9:0]), 64'd622);
                12: chk("bnc12.x", 64'(BulletX[9:0]), 64'd620);
                22: chk("bnc22.x", 64'(BulletX[9:0]), 64'd600);
                23: chk("bnc23.x", 64'(BulletX[9:0]), 64'd602);
                33: begin
                    chk("bnc33.x",   64'(BulletX[9:0]), 64'd622);
                    chk("bnc33.act", 64'(bullet_active), 64'h1);
                end
                34: begin
                    chk("bnc34.act", 64'(bullet_active), 64'h0);
                    chk("bnc34.x",   64'(BulletX[9:0]), 64'd622);
                end
                default: ;
            endcase
        end

        // Lifetime: live for 120 frames including the spawn frame.
        do_reset();
        shoot = 1'b1; keycode = 8'h52; playerX = 10'd300; playerY = 10'd400;
        step();
        idle_inputs();
        for (int k = 1; k <= 120; k++) begin
            step();
            if (k == 119) begin
                chk("life119.act", 64'(bullet_active), 64'h1);
                chk("life119.y",   64'(BulletY[9:0]), 64'd162);
            end
            if (k == 120) begin
                chk("life120.act", 64'(bullet_active), 64'h0);
                chk("life120.y",   64'(BulletY[9:0]), 64'd162);
                chk("life120.cnt", 64'(active_count), 64'd0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
